// File: rtl/rover_key_pkg.sv
// Shared constants and types for the rover pushbutton conditioner.
// Pins are active-low, so the idle (released) level is a logic one.
package rover_key_pkg;

    localparam logic KEY_RELEASED            = 1'b1;
    localparam int   DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int   CLK_HZ                  = 50000000;

    // IDLE: synchronised pin agrees with the clean level.
    // QUALIFY: they disagree and the stability counter is running.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_QUALIFY = 1'b1
    } deb_state_e;

endpackage

// File: rtl/rover_key_debounce_ch.sv
// One pushbutton channel: two-flop synchroniser, stability counter,
// clean level flop and registered press/release strobes.
module rover_key_debounce_ch
    import rover_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_clean,
    output logic key_press,
    output logic key_release
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             sync_q;
    logic             clean_q;
    logic             clean_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;
    deb_state_e       state_q;
    deb_state_e       state_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q      <= KEY_RELEASED;
            sync_q    <= KEY_RELEASED;
            clean_q   <= KEY_RELEASED;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= key_raw;
            sync_q    <= s1_q;
            clean_q   <= clean_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Any return to agreement while qualifying throws away all progress.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clean_d   = clean_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync_q != clean_q) begin
                    state_d = ST_QUALIFY;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_QUALIFY: begin
                if (sync_q == clean_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    clean_d   = sync_q;
                    press_d   = ~sync_q;
                    release_d = sync_q;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_clean   = clean_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/rover_key_debounce.sv
// Multi-key debouncer feeding the key PIO in_port; one independent
// channel per key, outputs concatenated in key order.
module rover_key_debounce
    import rover_key_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_clean,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    // A single-cycle window would let the counter compare never fire.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("rover_key_debounce: DEBOUNCE_CYCLES must be at least 2");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        rover_key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .key_raw     (key_raw[i]),
            .key_clean   (key_clean[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

endmodule

// File: tb/tb_rover_key_debounce.sv
// Directed bench for rover_key_debounce with an 8-cycle window; every
// expected value below is worked out by hand from the edge timing.
module tb_rover_key_debounce;

    logic       clk;
    logic       reset_n;
    logic [1:0] key_raw;
    logic [1:0] key_clean;
    logic [1:0] key_press;
    logic [1:0] key_release;

    int tests    = 0;
    int failures = 0;

    rover_key_debounce #(
        .NUM_KEYS        (2),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_raw     (key_raw),
        .key_clean   (key_clean),
        .key_press   (key_press),
        .key_release (key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] raw, input logic rstn);
        key_raw = raw;
        reset_n = rstn;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] ec,
                               input logic [1:0] ep, input logic [1:0] er);
        tests++;
        assert (key_clean === ec) else begin
            failures++;
            $error("[TB] FAIL %s key_clean observed=%b expected=%b", tag, key_clean, ec);
        end
        tests++;
        assert (key_press === ep) else begin
            failures++;
            $error("[TB] FAIL %s key_press observed=%b expected=%b", tag, key_press, ep);
        end
        tests++;
        assert (key_release === er) else begin
            failures++;
            $error("[TB] FAIL %s key_release observed=%b expected=%b", tag, key_release, er);
        end
    endtask

    // Advance n edges, sampling 1 time unit after each and expecting constant outputs.
    task automatic holdCheck(input string tag, input int n, input logic [1:0] ec,
                             input logic [1:0] ep, input logic [1:0] er);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checkOutput(tag, ec, ep, er);
        end
    endtask

    initial begin
        applyStimulus(2'b00, 1'b0);
        holdCheck("reset", 3, 2'b11, 2'b00, 2'b00);

        // Both keys held through reset: fall on the 10th edge after release.
        applyStimulus(2'b00, 1'b1);
        holdCheck("reset_hold", 9, 2'b11, 2'b00, 2'b00);
        holdCheck("reset_press", 1, 2'b00, 2'b11, 2'b00);
        holdCheck("reset_press_end", 1, 2'b00, 2'b00, 2'b00);

        applyStimulus(2'b11, 1'b1);
        holdCheck("both_rel_wait", 9, 2'b00, 2'b00, 2'b00);
        holdCheck("both_release", 1, 2'b11, 2'b00, 2'b11);
        holdCheck("both_rel_end", 1, 2'b11, 2'b00, 2'b00);

        applyStimulus(2'b10, 1'b1);
        holdCheck("press0_wait", 9, 2'b11, 2'b00, 2'b00);
        holdCheck("press0", 1, 2'b10, 2'b01, 2'b00);
        holdCheck("press0_held", 4, 2'b10, 2'b00, 2'b00);

        applyStimulus(2'b11, 1'b1);
        holdCheck("rel0_wait", 9, 2'b10, 2'b00, 2'b00);
        holdCheck("rel0", 1, 2'b11, 2'b00, 2'b01);
        holdCheck("rel0_end", 1, 2'b11, 2'b00, 2'b00);

        // Key 1 bounces every 3 cycles before settling low.
        applyStimulus(2'b01, 1'b1);
        holdCheck("bounce", 3, 2'b11, 2'b00, 2'b00);
        applyStimulus(2'b11, 1'b1);
        holdCheck("bounce", 3, 2'b11, 2'b00, 2'b00);
        applyStimulus(2'b01, 1'b1);
        holdCheck("bounce", 3, 2'b11, 2'b00, 2'b00);
        applyStimulus(2'b11, 1'b1);
        holdCheck("bounce", 3, 2'b11, 2'b00, 2'b00);
        applyStimulus(2'b01, 1'b1);
        holdCheck("bounce_settle", 9, 2'b11, 2'b00, 2'b00);
        holdCheck("bounce_press1", 1, 2'b01, 2'b10, 2'b00);
        holdCheck("bounce_held", 1, 2'b01, 2'b00, 2'b00);

        applyStimulus(2'b11, 1'b1);
        holdCheck("rel1_wait", 9, 2'b01, 2'b00, 2'b00);
        holdCheck("rel1", 1, 2'b11, 2'b00, 2'b10);
        holdCheck("rel1_end", 1, 2'b11, 2'b00, 2'b00);

        // Seven-cycle glitch reaches cnt = 7 but never gets the accepting edge.
        applyStimulus(2'b10, 1'b1);
        holdCheck("glitch7", 7, 2'b11, 2'b00, 2'b00);
        applyStimulus(2'b11, 1'b1);
        holdCheck("glitch7_after", 10, 2'b11, 2'b00, 2'b00);

        // Nine-cycle pulse: press lands on the edge where raw returns high.
        applyStimulus(2'b10, 1'b1);
        holdCheck("pulse9", 9, 2'b11, 2'b00, 2'b00);
        applyStimulus(2'b11, 1'b1);
        holdCheck("pulse9_press", 1, 2'b10, 2'b01, 2'b00);
        holdCheck("pulse9_low", 8, 2'b10, 2'b00, 2'b00);
        holdCheck("pulse9_release", 1, 2'b11, 2'b00, 2'b01);
        holdCheck("pulse9_end", 1, 2'b11, 2'b00, 2'b00);

        // One-cycle reset during qualification restarts from scratch.
        applyStimulus(2'b10, 1'b1);
        holdCheck("mid_qualify", 5, 2'b11, 2'b00, 2'b00);
        applyStimulus(2'b10, 1'b0);
        holdCheck("mid_reset", 1, 2'b11, 2'b00, 2'b00);
        applyStimulus(2'b10, 1'b1);
        holdCheck("after_reset_wait", 9, 2'b11, 2'b00, 2'b00);
        holdCheck("after_reset_press", 1, 2'b10, 2'b01, 2'b00);
        holdCheck("after_reset_held", 1, 2'b10, 2'b00, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
